// File: rtl/fetch_stage_if.sv
// Instruction-memory read port: one request in flight, response
// flagged by rvalid exactly once per accepted request.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, keeps one imem read in flight,
// parks a stalled return in a skid buffer and loads IF/ID.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  fetch_stage_if.master imem,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [31:0] PC
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_fl_q;
  logic        drop_q;
  logic [31:0] buf_inst_q;
  logic [31:0] buf_pc_q;
  logic        valid_q;
  logic [31:0] inst_q;
  logic [31:0] ipc_q;
  logic [31:0] ipc4_q;

  logic [31:0] fl4_d;
  logic [31:0] buf4_d;
  logic [31:0] tgt_d;
  logic        in_fetch;
  logic        in_wait;
  logic        chain_d;
  logic        accept_d;

  assign in_fetch = (state_q == FETCH);
  assign in_wait  = (state_q == WAIT);
  assign fl4_d    = pc_fl_q + 32'd4;
  assign buf4_d   = buf_pc_q + 32'd4;
  assign tgt_d    = {redirect_pc[31:2], 2'b00};

  // A live return may immediately chain the next sequential read.
  assign chain_d  = in_wait & imem.imem_rvalid & ~drop_q
                  & ~stall & ~redirect;

  assign imem.imem_req  = rst & ((in_fetch & ~redirect) | chain_d);
  assign imem.imem_addr = in_wait ? fl4_d : pc_q;
  assign accept_d       = imem.imem_req & imem.imem_ready;

  assign id_valid = valid_q;
  assign id_inst  = inst_q;
  assign id_pc    = ipc_q;
  assign id_pc4   = ipc4_q;
  assign PC       = pc_q;

  // Fetch FSM with PC, in-flight tracking, skid buffer and IF/ID.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      pc_fl_q    <= 32'd0;
      drop_q     <= 1'b0;
      buf_inst_q <= 32'd0;
      buf_pc_q   <= 32'd0;
      valid_q    <= 1'b0;
      inst_q     <= 32'd0;
      ipc_q      <= 32'd0;
      ipc4_q     <= 32'd0;
    end else if (redirect) begin
      pc_q    <= tgt_d;
      valid_q <= 1'b0;
      if (in_wait && !imem.imem_rvalid) begin
        drop_q <= 1'b1;
      end else begin
        drop_q  <= 1'b0;
        state_q <= FETCH;
      end
    end else begin
      unique case (state_q)
        FETCH: begin
          if (!stall) valid_q <= 1'b0;
          if (accept_d) begin
            pc_fl_q <= pc_q;
            drop_q  <= 1'b0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (!imem.imem_rvalid) begin
            if (!stall) valid_q <= 1'b0;
          end else if (drop_q) begin
            if (!stall) valid_q <= 1'b0;
            drop_q  <= 1'b0;
            state_q <= FETCH;
          end else if (!stall) begin
            valid_q <= 1'b1;
            inst_q  <= imem.imem_rdata;
            ipc_q   <= pc_fl_q;
            ipc4_q  <= fl4_d;
            pc_q    <= fl4_d;
            if (accept_d) begin
              pc_fl_q <= fl4_d;
            end else begin
              state_q <= FETCH;
            end
          end else begin
            buf_inst_q <= imem.imem_rdata;
            buf_pc_q   <= pc_fl_q;
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          if (!stall) begin
            valid_q <= 1'b1;
            inst_q  <= buf_inst_q;
            ipc_q   <= buf_pc_q;
            ipc4_q  <= buf4_d;
            pc_q    <= buf4_d;
            state_q <= FETCH;
          end
        end
        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic
// against an in-order instruction-stream reference model.
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [31:0] PC;

  fetch_stage_if imem();

  fetch_stage #(.RESET_PC(RPC)) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .imem(imem),
    .id_valid(id_valid),
    .id_inst(id_inst),
    .id_pc(id_pc),
    .id_pc4(id_pc4),
    .PC(PC)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model: next expected instruction address
  bit          mdl_en = 1'b0;
  logic [31:0] exp_next;
  logic        p_redir, p_stall, p_valid;
  logic [31:0] p_inst, p_pc, p_pc4;
  int          loads = 0;

  // memory model
  bit          m_busy = 1'b0;
  int          m_wait = 0;
  logic [31:0] m_addr = 32'd0;
  int          lat = 1;
  bit          acc;
  logic [31:0] acc_addr;
  logic [31:0] last_acc = 32'd0;
  int          n_acc = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mdl_init();
    mdl_en   = 1'b1;
    exp_next = RPC;
    p_redir  = 1'b0;
    p_stall  = 1'b0;
    p_valid  = 1'b0;
    p_inst   = 32'd0;
    p_pc     = 32'd0;
    p_pc4    = 32'd0;
  endtask

  task automatic model_check();
    if (p_redir) begin
      chk("flush_valid", {31'd0, id_valid}, 32'd0);
    end else if (p_stall) begin
      chk("hold_valid", {31'd0, id_valid}, {31'd0, p_valid});
      chk("hold_inst", id_inst, p_inst);
      chk("hold_pc", id_pc, p_pc);
      chk("hold_pc4", id_pc4, p_pc4);
    end else if (id_valid === 1'b1) begin
      chk("seq_pc", id_pc, exp_next);
      chk("seq_inst", id_inst, exp_next + 32'h100);
      chk("seq_pc4", id_pc4, exp_next + 32'd4);
      exp_next = exp_next + 32'd4;
      loads++;
    end else begin
      chk("bubble_pc", id_pc, p_pc);
      chk("bubble_inst", id_inst, p_inst);
    end
    p_redir = redirect;
    p_stall = stall;
    p_valid = id_valid;
    p_inst  = id_inst;
    p_pc    = id_pc;
    p_pc4   = id_pc4;
    if (redirect) exp_next = redirect_pc & ~32'h3;
  endtask

  task automatic mem_step();
    if (acc) begin
      chk("one_outstanding",
          {31'd0, m_busy && !imem.imem_rvalid}, 32'd0);
      chk("addr_aligned", {30'd0, acc_addr[1:0]}, 32'd0);
    end
    if (imem.imem_rvalid) begin
      m_busy = 1'b0;
      imem.imem_rvalid = 1'b0;
    end
    if (acc) begin
      m_busy   = 1'b1;
      m_addr   = acc_addr;
      m_wait   = lat;
      last_acc = acc_addr;
      n_acc++;
    end
    if (m_busy && !imem.imem_rvalid) begin
      if (m_wait <= 1) begin
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = m_addr + 32'h100;
      end else begin
        m_wait--;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (mdl_en) model_check();
    acc = (imem.imem_req === 1'b1) && (imem.imem_ready === 1'b1);
    acc_addr = imem.imem_addr;
    @(posedge clk);
    #1;
    mem_step();
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (id_valid !== 1'b1 && n < 50);
    chk(tag, {31'd0, id_valid}, 32'd1);
  endtask

  task automatic wait_acc(input string tag);
    int n = 0;
    int a0 = n_acc;
    do begin
      tick();
      n++;
    end while (n_acc == a0 && n < 50);
    chk(tag, {31'd0, n_acc != a0}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int l0;
    imem.imem_ready  = 1'b1;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = 32'd0;

    // reset values
    tick();
    tick();
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_inst", id_inst, 32'd0);
    chk("rst_pc", id_pc, 32'd0);
    chk("rst_pc4", id_pc4, 32'd0);
    chk("rst_PC", PC, RPC);
    chk("rst_req", {31'd0, imem.imem_req}, 32'd0);

    // release and stream with 1-cycle memory, across the wrap
    rst = 1'b1;
    mdl_init();
    #1;
    chk("req_after_rst", {31'd0, imem.imem_req}, 32'd1);
    chk("addr_after_rst", imem.imem_addr, RPC);
    tick();
    chk("lat_c1", {31'd0, id_valid}, 32'd0);
    tick();
    chk("lat_c2", {31'd0, id_valid}, 32'd1);
    chk("first_pc", id_pc, RPC);
    chk("lead_PC0", PC, id_pc + 32'd4);
    tick();
    chk("wrap_pc", id_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", id_pc4, 32'd0);
    chk("lead_PC1", PC, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stream_valid", {31'd0, id_valid}, 32'd1);
      chk("lead_PC", PC, id_pc + 32'd4);
    end
    chk("pc_at_8", id_pc, 32'd8);

    // stall three cycles with id_pc = 8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", id_pc, 32'd8);
      chk("stall_valid", {31'd0, id_valid}, 32'd1);
    end
    stall = 1'b0;
    tick();
    chk("unstall_pc12", id_pc, 32'd12);
    chk("unstall_v12", {31'd0, id_valid}, 32'd1);
    wait_valid("unstall_wait16");
    chk("unstall_pc16", id_pc, 32'd16);

    // redirect while a 4-cycle read is outstanding
    lat = 4;
    wait_acc("slow_acc");
    redirect = 1'b1;
    redirect_pc = 32'h0000_0043;
    tick();
    redirect = 1'b0;
    chk("redir_flush", {31'd0, id_valid}, 32'd0);
    chk("redir_PC", PC, 32'h40);
    chk("redir_no_req", {31'd0, imem.imem_req}, 32'd0);
    lat = 1;
    wait_acc("redir_acc");
    chk("redir_addr", last_acc, 32'h40);
    wait_valid("redir_wait");
    chk("redir_id_pc", id_pc, 32'h40);
    chk("redir_id_inst", id_inst, 32'h140);

    // redirect and stall together while holding a buffered word
    stall = 1'b1;
    tick();
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    stall = 1'b0;
    chk("rs_flush", {31'd0, id_valid}, 32'd0);
    chk("rs_PC", PC, 32'h200);
    wait_valid("rs_wait");
    chk("rs_id_pc", id_pc, 32'h200);

    // asynchronous reset in the middle of a long read
    lat = 6;
    wait_acc("ar_acc");
    #2;
    rst = 1'b0;
    mdl_en = 1'b0;
    #1;
    chk("ar_valid", {31'd0, id_valid}, 32'd0);
    chk("ar_inst", id_inst, 32'd0);
    chk("ar_pc", id_pc, 32'd0);
    chk("ar_pc4", id_pc4, 32'd0);
    chk("ar_PC", PC, RPC);
    chk("ar_req", {31'd0, imem.imem_req}, 32'd0);
    imem.imem_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    mdl_init();
    lat = 1;
    for (int n = 0; n < 20 && m_busy; n++) tick();
    chk("ar_stale_ignored", {31'd0, id_valid}, 32'd0);
    chk("ar_PC_kept", PC, RPC);
    imem.imem_ready = 1'b1;
    wait_valid("ar_wait");
    chk("ar_first_pc", id_pc, RPC);

    // random traffic
    l0 = loads;
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom % 5) == 0;
      redirect = ($urandom % 20) == 0;
      redirect_pc = $urandom;
      imem.imem_ready = ($urandom % 4) != 0;
      lat = $urandom_range(1, 4);
      tick();
    end
    stall = 1'b0;
    redirect = 1'b0;
    imem.imem_ready = 1'b1;
    lat = 1;
    for (int i = 0; i < 10; i++) tick();
    chk("rand_progress", {31'd0, (loads - l0) > 150}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
